// File: rtl/first_nios2_system_cpu_mulx_seq.sv
// ---------------------------------------------------------------------------
// first_nios2_system_cpu_mulx_seq
//
// Multi-cycle 32x32 multiply sequencer for the Nios II M-stage. It builds the
// 64-bit product from four 16x16 unsigned partial products. Each partial
// product comes from a one-cycle-registered multiplier. A single CORR step
// then turns the unsigned product into the signed or mixed-sign product.
// Latency is fixed: start accepted at end of cycle 0, done in cycle 7.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   start    in   request, accepted only in IDLE
//   kill     in   abort of an in-flight op (no done, result kept)
//   op       in   00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   src1     in   operand A, sampled on accept
//   src2     in   operand B, sampled on accept
//   busy     out  state != IDLE (registered)
//   done     out  one-cycle pulse in DONE; result valid from this cycle
//   result   out  low word (MUL) or high word (MULX*), held until next done
// ---------------------------------------------------------------------------

// 16x16 unsigned multiplier with a registered product.
module first_nios2_system_cpu_mulx_seq_mul16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);
    always_ff @(posedge clk) begin
        if (!reset_n) p <= '0;
        else          p <= {16'b0, x} * {16'b0, y};
    end
endmodule

module first_nios2_system_cpu_mulx_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        kill,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_P3, S_ACC, S_CORR, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [63:0] acc, acc_nxt;
    logic [63:0] corr_a, corr_b;
    logic [15:0] mul_x, mul_y;
    logic [31:0] prod;

    // Operand mux follows the issuing state. Outside P1..P3 it selects the
    // low halves, which covers P0; the product is ignored in other states.
    always_comb begin
        mul_x = a_q[15:0];
        mul_y = b_q[15:0];
        case (state)
            S_P1:    mul_x = a_q[31:16];
            S_P2:    mul_y = b_q[31:16];
            S_P3:    begin mul_x = a_q[31:16]; mul_y = b_q[31:16]; end
            default: ;
        endcase
    end

    first_nios2_system_cpu_mulx_seq_mul16 u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (mul_x),
        .y       (mul_y),
        .p       (prod)
    );

    // Two's-complement fixup: a negative operand contributes an extra
    // 2^32 * other_operand to the unsigned product, so remove it here.
    assign corr_a = (op_q[1] && a_q[31])          ? {b_q, 32'b0} : 64'b0;
    assign corr_b = ((op_q == 2'b11) && b_q[31])  ? {a_q, 32'b0} : 64'b0;

    // The product register lags the issuing state by one cycle, so the state
    // that adds pp(n) is the one after the state that issued it.
    always_comb begin
        acc_nxt = acc;
        case (state)
            S_P1:    acc_nxt = acc + {32'b0, prod};
            S_P2:    acc_nxt = acc + {16'b0, prod, 16'b0};
            S_P3:    acc_nxt = acc + {16'b0, prod, 16'b0};
            S_ACC:   acc_nxt = acc + {prod, 32'b0};
            S_CORR:  acc_nxt = acc - corr_a - corr_b;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (start) state_nxt = S_P0;
        end else if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_P0:    state_nxt = S_P1;
                S_P1:    state_nxt = S_P2;
                S_P2:    state_nxt = S_P3;
                S_P3:    state_nxt = S_ACC;
                S_ACC:   state_nxt = S_CORR;
                S_CORR:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
            if (state == S_IDLE) begin
                if (start) begin
                    a_q  <= src1;
                    b_q  <= src2;
                    op_q <= op;
                    acc  <= '0;
                end
            end else if (!kill) begin
                acc <= acc_nxt;
                // Load from acc_nxt so the correction made in CORR is included.
                if (state == S_CORR)
                    result <= (op_q == 2'b00) ? acc_nxt[31:0] : acc_nxt[63:32];
            end
        end
    end
endmodule

// File: tb/tb_first_nios2_system_cpu_mulx_seq.sv
module tb_first_nios2_system_cpu_mulx_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    first_nios2_system_cpu_mulx_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive start in cycle 0 (optionally with kill), then scramble operands
    // from cycle 1 on. Outputs are sampled on the falling edge of cycles 1..9.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit kill0);
        int first_done = -1;
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; kill = kill0; op = o; src1 = a; src2 = b;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; kill = 1'b0;
                src1 = ~a; src2 = b ^ 32'h5a5a_5a5a; op = ~o;
                chk({tag, "_busy1"}, busy, 1'b1);
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c == 7) chk({tag, "_res"}, result, exp);
            if (c == 8) chk({tag, "_idle8"}, {busy, done}, 2'b00);
        end
        chk({tag, "_lat"}, first_done, 7);
        chk({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        int dcyc[$];
        logic [31:0] held;
        reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00;
        src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {busy, done, result}, 34'h0);
        reset_n = 1'b1;

        // All-ones operands
        run_op("ones_mul",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("ones_uu",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("ones_su",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("ones_ss",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        // Min-negative operands
        run_op("mneg_uu",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mneg_su",   2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0);
        run_op("mneg_ss",   2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mneg_mul",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        // Carry propagation across the partial-product boundaries
        run_op("carry_mul", 2'b00, 32'h0001_FFFF, 32'h0001_FFFF, 32'hFFFC_0001, 1'b0);
        // start with kill in IDLE: start wins
        run_op("carry_uu",  2'b01, 32'h0001_FFFF, 32'h0001_FFFF, 32'h0000_0003, 1'b1);
        // Mixed signs: -2 * 3 (ss) = -6 -> high word all ones; 0x10000*0x10000 hi = 1
        run_op("mix_ss",    2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
        run_op("mix_uu",    2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0);

        // Kill in cycle 4: busy drops in cycle 5, no done, result held.
        held = 32'h0000_0001;
        begin
            int nd = 0;
            @(negedge clk);
            start = 1'b1; op = 2'b00; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 1) start = 1'b0;
                if (done) nd++;
                if (c == 4) kill = 1'b1;
                if (c == 5) begin
                    chk("kill_busy5", busy, 1'b0);
                    kill = 1'b0;
                end
            end
            chk("kill_ndone", nd, 0);
            chk("kill_res", result, held);
        end

        // Start pulses in cycles 3 and 7 are ignored; cycle 8 is accepted.
        @(negedge clk);
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) @(negedge clk);
            if (done) dcyc.push_back(c);
            if (c == 15) chk("sb_res", result, 32'h0000_0006);
            start = (c == 0 || c == 3 || c == 7 || c == 8);
            op = 2'b00;
            src1 = (c == 8) ? 32'h0000_0002 : 32'h0000_0005;
            src2 = (c == 8) ? 32'h0000_0003 : 32'h0000_0007;
            if (c == 7) chk("sb_res7", result, 32'h0000_0023);
        end
        chk("sb_ndone", dcyc.size(), 2);
        if (dcyc.size() == 2) begin
            chk("sb_done0", dcyc[0], 7);
            chk("sb_done1", dcyc[1], 15);
        end

        // Reset held for 2 cycles mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) reset_n = 1'b0;
            if (c == 5) begin
                reset_n = 1'b1;
                chk("rst_mid", {busy, done, result}, 34'h0);
            end
        end
        run_op("post_rst",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
